// File: rtl/multimode_counter.sv
// Runtime-selectable binary / modulo-MOD / ring / Johnson counter with load, reseed and cascadable tc.
// Optional build macro MULTIMODE_COUNTER_SATURATE_EN adds a sat input that holds binary/modulo at terminal.
module multimode_counter #(
    parameter int     WIDTH = 32'sd4,
    parameter longint MOD   = 64'sd10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MULTIMODE_COUNTER_SATURATE_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             load_err
);

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_MOD  = 2'd1;
    localparam logic [1:0] MODE_RING = 2'd2;
    localparam logic [1:0] MODE_JOHN = 2'd3;

    localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RING_SEED  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] RING_TC_DN = RING_SEED >> 1;
    localparam logic [WIDTH-1:0] MOD_TOP    = WIDTH'(MOD - 64'sd1);
    localparam logic [63:0]      MOD_U      = 64'(MOD);

    // Reject out-of-range parameters when the design is elaborated.
    if (WIDTH < 32'sd2 || WIDTH > 32'sd32) begin : g_bad_width
        $error("multimode_counter: WIDTH must be in 2..32");
    end
    if (MOD < 64'sd2 || MOD > (64'sd1 << WIDTH)) begin : g_bad_mod
        $error("multimode_counter: MOD must be in 2..2**WIDTH");
    end

    function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
        case (m)
            MODE_RING: seed_of = RING_SEED;
            default:   seed_of = ZERO;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] step_of(input logic [1:0] m, input logic d,
                                                 input logic [WIDTH-1:0] q);
        case (m)
            MODE_BIN: begin
                if (d) step_of = q - ONE;
                else   step_of = q + ONE;
            end
            MODE_MOD: begin
                if (d) step_of = (q == ZERO) ? MOD_TOP : q - ONE;
                else   step_of = (q == MOD_TOP) ? ZERO : q + ONE;
            end
            MODE_RING: begin
                if (d) step_of = {q[WIDTH-2:0], q[WIDTH-1]};
                else   step_of = {q[0], q[WIDTH-1:1]};
            end
            default: begin
                if (d) step_of = {q[WIDTH-2:0], ~q[WIDTH-1]};
                else   step_of = {~q[0], q[WIDTH-1:1]};
            end
        endcase
    endfunction

    // Terminal value: the count whose next enabled step wraps or returns to the seed.
    function automatic logic is_term(input logic [1:0] m, input logic d,
                                     input logic [WIDTH-1:0] q);
        case (m)
            MODE_BIN:  is_term = d ? (q == ZERO)       : (q == ONES);
            MODE_MOD:  is_term = d ? (q == ZERO)       : (q == MOD_TOP);
            MODE_RING: is_term = d ? (q == RING_TC_DN) : (q == ONE);
            default:   is_term = d ? (q == RING_SEED)  : (q == ONE);
        endcase
    endfunction

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        is_onehot = (v != ZERO) && ((v & (v - ONE)) == ZERO);
    endfunction

    logic [WIDTH-1:0] count_r;
    logic [1:0]       mode_r;
    logic             load_err_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             load_err_nxt_s;
    logic             mode_chg_s;
    logic             at_term_s;
    logic             sat_hold_s;

    assign mode_chg_s = (mode != mode_r);
    assign at_term_s  = is_term(mode, dir, count_r);

    // Saturation only applies to the arithmetic modes.
`ifdef MULTIMODE_COUNTER_SATURATE_EN
    assign sat_hold_s = sat && at_term_s && ((mode == MODE_BIN) || (mode == MODE_MOD));
`else
    assign sat_hold_s = 1'b0;
`endif

    // Next-state selection: reseed beats load beats enable beats hold.
    always_comb begin
        count_nxt_s    = count_r;
        load_err_nxt_s = 1'b0;
        if (mode_chg_s) begin
            count_nxt_s = seed_of(mode);
        end else if (load) begin
            case (mode)
                MODE_MOD: begin
                    if ({{(64-WIDTH){1'b0}}, load_val} >= MOD_U) begin
                        count_nxt_s    = ZERO;
                        load_err_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = load_val;
                    end
                end
                MODE_RING: begin
                    if (!is_onehot(load_val)) begin
                        count_nxt_s    = RING_SEED;
                        load_err_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = load_val;
                    end
                end
                default: count_nxt_s = load_val;
            endcase
        end else if (en) begin
            if (sat_hold_s) count_nxt_s = count_r;
            else            count_nxt_s = step_of(mode, dir, count_r);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r    <= ZERO;
            mode_r     <= MODE_BIN;
            load_err_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            mode_r     <= mode;
            load_err_r <= load_err_nxt_s;
        end
    end

    assign count    = count_r;
    assign load_err = load_err_r;
    assign tc       = en && !mode_chg_s && at_term_s;

endmodule
